// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: tag-pipeline operand forwarding, load-use stall and branch flush control.
// Stall/flush performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_fwd_unit #(
  parameter int RA_W         = 2,
  parameter int DEPTH        = 2,
  parameter int LOAD_STAGE   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int SEL_W        = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_src1,
  input  logic [RA_W-1:0]  id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RA_W-1:0]  id_dst,
  input  logic             id_wr,
  input  logic             id_is_load,
  input  logic             branch_taken,
  output logic [SEL_W-1:0] fwd1_sel,
  output logic [SEL_W-1:0] fwd2_sel,
  output logic             fwd1_mem,
  output logic             fwd2_mem,
  output logic             stall,
  output logic             flush,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dst;
    logic            is_load;
  } tag_t;

  typedef enum logic {RUN, FLUSH} state_t;

  tag_t             tag_q [DEPTH];
  tag_t             tag0_d;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic [SEL_W-1:0] sel1_raw, sel2_raw;
  logic             mem1_raw, mem2_raw;
  logic             lu1, lu2;

  // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
  always_comb begin
    sel1_raw = SEL_W'(DEPTH);
    sel2_raw = SEL_W'(DEPTH);
    mem1_raw = 1'b0;
    mem2_raw = 1'b0;
    lu1      = 1'b0;
    lu2      = 1'b0;
    // Scan oldest to youngest so the youngest match is the one left standing.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tag_q[i].valid && tag_q[i].dst == id_src1 && id_use1) begin
        sel1_raw = SEL_W'(i);
        mem1_raw = tag_q[i].is_load;
        lu1      = tag_q[i].is_load && (i < LOAD_STAGE);
      end
      if (tag_q[i].valid && tag_q[i].dst == id_src2 && id_use2) begin
        sel2_raw = SEL_W'(i);
        mem2_raw = tag_q[i].is_load;
        lu2      = tag_q[i].is_load && (i < LOAD_STAGE);
      end
    end
  end

  assign flush    = branch_taken | (state_q == FLUSH);
  assign stall    = id_valid & ~flush & (lu1 | lu2);
  assign fwd1_sel = flush ? SEL_W'(DEPTH) : sel1_raw;
  assign fwd2_sel = flush ? SEL_W'(DEPTH) : sel2_raw;
  assign fwd1_mem = ~flush & mem1_raw;
  assign fwd2_mem = ~flush & mem2_raw;

  always_comb begin
    tag0_d = '0;
    if (!(stall || flush)) begin
      tag0_d.valid   = id_valid & id_wr;
      tag0_d.dst     = id_dst;
      tag0_d.is_load = id_is_load;
    end
  end

  // NOTE: the tag pipeline is a handful of flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage see the pre-edge value of its neighbour.
      tag_q[0] <= tag0_d;
      for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (branch_taken) begin
      if (FLUSH_CYCLES > 1) begin
        state_q <= FLUSH;
        cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
      end
    end else if (state_q == FLUSH) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) state_q <= RUN;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenarios then random traffic against a
// history-queue reference model.
module tb_hazard_fwd_unit;

  localparam int RA_W         = 2;
  localparam int DEPTH        = 2;
  localparam int LOAD_STAGE   = 1;
  localparam int FLUSH_CYCLES = 3;
  localparam int SEL_W        = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             id_valid, id_use1, id_use2, id_wr, id_is_load, branch_taken;
  logic [RA_W-1:0]  id_src1, id_src2, id_dst;
  logic [SEL_W-1:0] fwd1_sel, fwd2_sel;
  logic             fwd1_mem, fwd2_mem, stall, flush;
  logic [15:0]      stall_cnt, flush_cnt;

  always #5 clock = ~clock;

  hazard_fwd_unit #(
    .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dst(id_dst), .id_wr(id_wr),
    .id_is_load(id_is_load), .branch_taken(branch_taken),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .fwd1_mem(fwd1_mem), .fwd2_mem(fwd2_mem),
    .stall(stall), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: hist[k] is the instruction that entered execute k+1 clocks ago.
  typedef struct {
    bit valid;
    int dst;
    bit is_load;
  } mtag_t;

  mtag_t hist[$];
  int    flush_left  = 0;
  int    m_stall_cnt = 0;
  int    m_flush_cnt = 0;
  bit    model_ok    = 0;
  int    e_sel1, e_sel2;
  bit    e_mem1, e_mem2, e_stall, e_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void find(input int src, input bit use_it, output int sel, output bit mem);
    bit found = 0;
    sel = DEPTH;
    mem = 0;
    if (use_it) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && hist[k].valid && hist[k].dst == src) begin
          found = 1;
          sel   = k;
          mem   = hist[k].is_load;
        end
      end
    end
  endfunction

  task automatic model_eval();
    e_flush = branch_taken || (flush_left > 0);
    find(int'(id_src1), id_use1, e_sel1, e_mem1);
    find(int'(id_src2), id_use2, e_sel2, e_mem2);
    e_stall = !e_flush && id_valid &&
              ((e_mem1 && e_sel1 < LOAD_STAGE) || (e_mem2 && e_sel2 < LOAD_STAGE));
    if (e_flush) begin
      e_sel1 = DEPTH; e_sel2 = DEPTH; e_mem1 = 0; e_mem2 = 0;
    end
  endtask

  task automatic model_clock();
    mtag_t t;
    if (!reset) begin
      hist.delete();
      t = '{valid: 0, dst: 0, is_load: 0};
      for (int k = 0; k < DEPTH; k++) hist.push_back(t);
      flush_left  = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
      model_ok    = 1;
    end else begin
`ifdef HAZARD_PERF_EN
      if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
      if (e_flush && m_flush_cnt < 65535) m_flush_cnt++;
`endif
      if (e_stall || e_flush) t = '{valid: 0, dst: 0, is_load: 0};
      else t = '{valid: id_valid && id_wr, dst: int'(id_dst), is_load: id_is_load};
      hist.push_front(t);
      void'(hist.pop_back());
      if (branch_taken) flush_left = FLUSH_CYCLES - 1;
      else if (flush_left > 0) flush_left--;
    end
  endtask

  task automatic cyc_check();
    @(negedge clock);
    model_eval();
    if (model_ok) begin
      check("fwd1_sel",  32'(fwd1_sel),  32'(e_sel1));
      check("fwd2_sel",  32'(fwd2_sel),  32'(e_sel2));
      check("fwd1_mem",  32'(fwd1_mem),  32'(e_mem1));
      check("fwd2_mem",  32'(fwd2_mem),  32'(e_mem2));
      check("stall",     32'(stall),     32'(e_stall));
      check("flush",     32'(flush),     32'(e_flush));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
    end
  endtask

  task automatic cyc_clock();
    model_eval();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic cyc();
    cyc_check();
    cyc_clock();
  endtask

  task automatic set_id(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                        input int d, input bit w, input bit ld, input bit br);
    id_valid = v;           id_src1 = RA_W'(s1);  id_use1 = u1;
    id_src2  = RA_W'(s2);   id_use2 = u2;         id_dst  = RA_W'(d);
    id_wr    = w;           id_is_load = ld;      branch_taken = br;
  endtask

  task automatic set_random(input bit allow_branch);
    set_id($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           allow_branch && ($urandom_range(0, 7) == 0));
  endtask

  initial begin
    // Reset held two cycles while decode inputs toggle.
    reset = 1'b0;
    for (int n = 0; n < 2; n++) begin
      set_random(0);
      cyc();
    end
    reset = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc_check();
    check("rst_fwd1_sel", 32'(fwd1_sel), 32'd2);
    check("rst_fwd2_sel", 32'(fwd2_sel), 32'd2);
    check("rst_stall",    32'(stall),    32'd0);
    check("rst_flush",    32'(flush),    32'd0);
    cyc_clock();

    // ALU forwarding from stage 0 then stage 1.
    set_id(1, 0, 0, 0, 0, 1, 1, 0, 0); cyc();
    set_id(1, 1, 1, 0, 0, 0, 0, 0, 0); cyc_check();
    check("alu_fwd1_sel", 32'(fwd1_sel), 32'd0);
    cyc_clock();
    set_id(1, 0, 0, 1, 1, 0, 0, 0, 0); cyc_check();
    check("alu_fwd2_sel", 32'(fwd2_sel), 32'd1);
    check("alu_fwd2_mem", 32'(fwd2_mem), 32'd0);
    cyc_clock();

    // Load-use: one stall cycle, then MDR forward from stage 1; stalled inst must not enter.
    set_id(1, 0, 0, 0, 0, 2, 1, 1, 0); cyc();
    set_id(1, 2, 1, 0, 0, 3, 1, 0, 0); cyc_check();
    check("lu_stall",     32'(stall),    32'd1);
    check("lu_fwd1_sel0", 32'(fwd1_sel), 32'd0);
    cyc_clock();
    set_id(1, 2, 1, 3, 1, 3, 1, 0, 0); cyc_check();
    check("lu_stall_clr", 32'(stall),    32'd0);
    check("lu_fwd1_sel1", 32'(fwd1_sel), 32'd1);
    check("lu_fwd1_mem",  32'(fwd1_mem), 32'd1);
    check("lu_bubble",    32'(fwd2_sel), 32'd2);
    cyc_clock();

    // Youngest writer wins.
    set_id(1, 0, 0, 0, 0, 3, 1, 1, 0); cyc();
    set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); cyc();
    set_id(1, 3, 1, 3, 1, 0, 0, 0, 0); cyc_check();
    check("yw_fwd1_sel", 32'(fwd1_sel), 32'd0);
    check("yw_fwd2_sel", 32'(fwd2_sel), 32'd0);
    id_use1 = 1'b0;
    #1;
    check("yw_nouse_sel1", 32'(fwd1_sel), 32'd2);
    check("yw_nouse_sel2", 32'(fwd2_sel), 32'd0);
    cyc_clock();

    // Taken branch with a load-use pending: three flush cycles, nothing inserted.
    set_id(1, 0, 0, 0, 0, 1, 1, 1, 0); cyc();
    for (int n = 0; n < 3; n++) begin
      set_id(1, 1, 1, 0, 0, 2, 1, 0, n == 0);
      cyc_check();
      check("br_flush",    32'(flush),    32'd1);
      check("br_stall",    32'(stall),    32'd0);
      check("br_fwd1_sel", 32'(fwd1_sel), 32'd2);
      check("br_fwd1_mem", 32'(fwd1_mem), 32'd0);
      cyc_clock();
    end
    set_id(1, 1, 1, 2, 1, 0, 0, 0, 0); cyc_check();
    check("br_flush_end", 32'(flush),    32'd0);
    check("br_no_insert", 32'(fwd2_sel), 32'd2);
    cyc_clock();

    // Random traffic, occasional branches and resets.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) != 0);
      set_random(1);
      cyc();
    end
    reset = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
